// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: records architectural register writes for a drain port.
// Capture never stalls the pipeline; overflow drops the write and counts it.
module wb_trace_fifo #(
    parameter int DEPTH        = 16,
    parameter int SKIP_R0      = 1,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_reg,
    input  logic [31:0]                wb_data,
    input  logic [31:0]                wb_pc,
    input  logic                       trace_ready,
    output logic                       trace_valid,
    output logic [31:0]                trace_pc,
    output logic [4:0]                 trace_reg,
    output logic [31:0]                trace_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                drop_count,
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state;

    logic [31:0]   mem_pc   [DEPTH];
    logic [4:0]    mem_reg  [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic cand;
    logic pop;
    logic push;
    logic drop;
    logic full;

    assign full = (level == LW'(DEPTH));
    assign cand = (state == ST_RUN) && wb_valid
                  && !((SKIP_R0 != 0) && (wb_reg == 5'd0));
    assign pop  = trace_valid && trace_ready;
    assign push = cand && (!full || pop);
    assign drop = cand && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (drop && (STOP_ON_FULL != 0)) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state  <= ST_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    // Storage needs no reset: payload is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= wb_pc;
            mem_reg[wr_ptr]  <= wb_reg;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    assign trace_valid = (level != '0);
    assign trace_pc    = trace_valid ? mem_pc[rd_ptr]   : '0;
    assign trace_reg   = trace_valid ? mem_reg[rd_ptr]  : '0;
    assign trace_data  = trace_valid ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: default instance plus a STOP_ON_FULL=1 instance.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        en2;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        trace_ready;
    logic        rdy2;

    logic        trace_valid, tv2;
    logic [31:0] trace_pc, tpc2;
    logic [4:0]  trace_reg, treg2;
    logic [31:0] trace_data, tdata2;
    logic [4:0]  level, level2;
    logic [15:0] drop_count, drop2;
    logic        halted, halted2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_trace_fifo #(.DEPTH(16), .SKIP_R0(1), .STOP_ON_FULL(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .trace_ready(trace_ready), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
        .level(level), .drop_count(drop_count), .halted(halted)
    );

    wb_trace_fifo #(.DEPTH(16), .SKIP_R0(1), .STOP_ON_FULL(1)) dut_h (
        .clk(clk), .rst(rst), .enable(en2), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .trace_ready(rdy2), .trace_valid(tv2),
        .trace_pc(tpc2), .trace_reg(treg2), .trace_data(tdata2),
        .level(level2), .drop_count(drop2), .halted(halted2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d,
                      input logic [31:0] p);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_data  = d;
        wb_pc    = p;
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; en2 = 1'b0; wb_valid = 1'b0;
        wb_reg = '0; wb_data = '0; wb_pc = '0;
        trace_ready = 1'b0; rdy2 = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_data", trace_data, 32'd0);

        // write in the enable-rise cycle is not captured
        enable = 1'b1;
        wr(5'd9, 32'd99, 32'h10);
        chk("en_rise_level", 32'(level), 32'd0);

        wr(5'd8, 32'h5, 32'h4);
        chk("t1_valid", 32'(trace_valid), 32'd1);
        chk("t1_reg", 32'(trace_reg), 32'd8);
        chk("t1_data", trace_data, 32'd5);
        chk("t1_pc", trace_pc, 32'h4);
        chk("t1_level", 32'(level), 32'd1);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        chk("t1_empty_valid", 32'(trace_valid), 32'd0);
        chk("t1_empty_data", trace_data, 32'd0);

        wr(5'd0, 32'hDEAD, 32'h8);
        chk("t2_level", 32'(level), 32'd0);
        chk("t2_drop", 32'(drop_count), 32'd0);

        for (int i = 1; i <= 18; i++) wr(5'(i), 32'(i), 32'(4 * i));
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_drop", 32'(drop_count), 32'd2);
        step();
        chk("t3_hold_data", trace_data, 32'd1);
        chk("t3_hold_pc", trace_pc, 32'd4);
        trace_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t3_drain", trace_data, 32'(i));
            step();
        end
        trace_ready = 1'b0;
        chk("t3_level_end", 32'(level), 32'd0);

        for (int i = 1; i <= 16; i++) wr(5'd3, 32'(100 + i), 32'h0);
        chk("t4_full", 32'(level), 32'd16);
        trace_ready = 1'b1;
        wr(5'd4, 32'd200, 32'h0);
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_drop", 32'(drop_count), 32'd2);
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain", trace_data, (i < 15) ? 32'(102 + i) : 32'd200);
            step();
        end
        trace_ready = 1'b0;
        chk("t4_level_end", 32'(level), 32'd0);

        for (int i = 1; i <= 5; i++) wr(5'd6, 32'(300 + i), 32'h0);
        chk("t6_level5", 32'(level), 32'd5);
        rst = 1'b1;
        wr(5'd6, 32'd399, 32'h0);
        rst = 1'b0;
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_valid", 32'(trace_valid), 32'd0);
        chk("t6_drop", 32'(drop_count), 32'd0);
        wr(5'd6, 32'd7, 32'h0);
        chk("t6_idle", 32'(level), 32'd0);
        enable = 1'b0;
        step();

        en2 = 1'b1;
        step();
        for (int i = 1; i <= 17; i++) wr(5'd2, 32'(i), 32'h0);
        chk("t5_halted", 32'(halted2), 32'd1);
        chk("t5_level", 32'(level2), 32'd16);
        chk("t5_drop", 32'(drop2), 32'd1);
        wr(5'd2, 32'd77, 32'h0);
        wr(5'd2, 32'd78, 32'h0);
        chk("t5_drop_hold", 32'(drop2), 32'd1);
        chk("t5_level_hold", 32'(level2), 32'd16);
        rdy2 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t5_drain", tdata2, 32'(i));
            step();
        end
        rdy2 = 1'b0;
        chk("t5_empty", 32'(level2), 32'd0);
        chk("t5_still_halted", 32'(halted2), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_halted", 32'(halted2), 32'd0);
        chk("t5_rst_level", 32'(level2), 32'd0);
        chk("t5_rst_drop", 32'(drop2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
